// File: rtl/calc_key_sequencer.sv
// Key-entry sequencer for the 4-bit calculator core: assembles A, operator and B,
// then presents them stable and strobes get_res once per accepted equals.
module calc_key_sequencer #(
    parameter int unsigned PULSE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [3:0] input_a,
    output logic [3:0] input_b,
    output logic [2:0] func,
    output logic       get_res,
    output logic       busy,
    output logic       err_div0,
    output logic       key_drop
);

    typedef enum logic [2:0] {
        S_A,
        S_BW,
        S_B,
        S_SETUP,
        S_PULSE,
        S_DONE
    } state_t;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [3:0] a_next, b_next;
    logic [2:0] func_next;
    logic       err_next, drop_next;
    logic       is_digit, is_op, is_eq, is_clr, is_known, in_eval;

    assign is_digit = ~key_code[4];
    assign is_op    = key_code[4] && (key_code[3:0] <= 4'h5);
    assign is_eq    = (key_code == 5'h1E);
    assign is_clr   = (key_code == 5'h1F);
    assign is_known = is_digit | is_op | is_eq | is_clr;
    assign in_eval  = (state == S_SETUP) || (state == S_PULSE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        a_next     = input_a;
        b_next     = input_b;
        func_next  = func;
        err_next   = err_div0;
        drop_next  = 1'b0;

        case (state)
            S_A: begin
                if (key_valid && is_digit) begin
                    a_next   = key_code[3:0];
                    err_next = 1'b0;
                end else if (key_valid && is_op) begin
                    func_next  = key_code[2:0];
                    err_next   = 1'b0;
                    state_next = S_BW;
                end
            end
            S_BW: begin
                if (key_valid && is_digit) begin
                    b_next     = key_code[3:0];
                    err_next   = 1'b0;
                    state_next = S_B;
                end else if (key_valid && is_op) begin
                    func_next = key_code[2:0];
                    err_next  = 1'b0;
                end
            end
            S_B: begin
                if (key_valid && is_digit) begin
                    b_next   = key_code[3:0];
                    err_next = 1'b0;
                end else if (key_valid && is_op) begin
                    func_next = key_code[2:0];
                    err_next  = 1'b0;
                end else if (key_valid && is_eq) begin
                    // Division by zero never reaches the core; the operands stay editable.
                    if (func == 3'b011 && input_b == 4'h0) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                drop_next  = key_valid && is_known;
                cnt_next   = PULSE_LOAD;
                state_next = S_PULSE;
            end
            S_PULSE: begin
                drop_next = key_valid && is_known;
                if (cnt <= 8'd1) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            S_DONE: begin
                if (key_valid && is_digit) begin
                    a_next     = key_code[3:0];
                    b_next     = 4'h0;
                    err_next   = 1'b0;
                    state_next = S_A;
                end else if (key_valid && is_eq) begin
                    state_next = S_SETUP;
                end
            end
            default: state_next = S_A;
        endcase

        if (key_valid && is_clr && !in_eval) begin
            a_next     = 4'h0;
            b_next     = 4'h0;
            func_next  = 3'b000;
            err_next   = 1'b0;
            state_next = S_A;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            cnt      <= 8'd0;
            input_a  <= 4'h0;
            input_b  <= 4'h0;
            func     <= 3'b000;
            err_div0 <= 1'b0;
            key_drop <= 1'b0;
            get_res  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            input_a  <= a_next;
            input_b  <= b_next;
            func     <= func_next;
            err_div0 <= err_next;
            key_drop <= drop_next;
            get_res  <= (state_next == S_PULSE);
            busy     <= (state_next == S_SETUP) || (state_next == S_PULSE);
        end
    end

endmodule
